// File: rtl/mem_stream_loader_pkg.sv
// Shared types and helpers for the weight/delay memory stream loader.
// Holds the FSM encoding, the mode constants and the wrapping address step.
package mem_stream_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic MODE_WRITE = 1'b0;
    localparam logic MODE_READ  = 1'b1;

    // The word count need not be a power of two, so the wrap is an explicit
    // compare rather than a natural binary rollover.
    function automatic int next_addr(input int addr, input int words);
        return (addr == words - 1) ? 0 : addr + 1;
    endfunction

endpackage

// File: rtl/mem_stream_loader.sv
// Initiator-side sequencer for the weight/delay memory: loads M words from a
// valid/ready stream, or streams them back out, keeping a running checksum.
module mem_stream_loader
    import mem_stream_loader_pkg::*;
#(
    parameter int  M      = 320,
    parameter int  N      = 8,
    localparam int ADDR_W = (M > 1) ? $clog2(M) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [N-1:0]      in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [N-1:0]      out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [N-1:0]      mem_wdata,
    output logic              mem_we,
    input  logic [N-1:0]      mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [N-1:0]      checksum
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [N-1:0]        r_sum;

    state_t              w_state_next;
    logic [ADDR_W-1:0]   w_addr_next;
    logic [N-1:0]        w_sum_next;
    logic                w_xfer;
    logic [N-1:0]        w_xfer_data;

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_sum_next   = r_sum;
        w_xfer       = 1'b0;
        w_xfer_data  = in_data;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (mode == MODE_READ) ? ST_READ : ST_WRITE;
                    w_addr_next  = '0;
                    w_sum_next   = '0;
                end
            end
            ST_WRITE: begin
                w_xfer      = in_valid;
                w_xfer_data = in_data;
            end
            ST_READ: begin
                w_xfer      = out_ready;
                w_xfer_data = mem_rdata;
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Shared word-accept step for both directions.
        if (w_xfer) begin
            w_sum_next  = r_sum + w_xfer_data;
            w_addr_next = ADDR_W'(next_addr(int'(r_addr), M));
            if (int'(r_addr) == M - 1) begin
                w_state_next = ST_DONE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the reset is asynchronous and active-high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_sum   <= '0;
        end else begin
            r_state <= w_state_next;
            r_addr  <= w_addr_next;
            r_sum   <= w_sum_next;
        end
    end

    // Write data and enable are combinational so a word lands in memory on the
    // same edge that accepts it.
    assign mem_addr  = r_addr;
    assign mem_wdata = in_data;
    assign mem_we    = (r_state == ST_WRITE) && in_valid;
    assign in_ready  = (r_state == ST_WRITE);
    assign out_valid = (r_state == ST_READ);
    assign out_data  = (r_state == ST_READ) ? mem_rdata : '0;
    assign busy      = (r_state == ST_WRITE) || (r_state == ST_READ);
    assign done      = (r_state == ST_DONE);
    assign checksum  = r_sum;

endmodule

// File: tb/tb_mem_stream_loader.sv
// Scoreboard bench for mem_stream_loader with M=6 and a behavioural memory.
// Stimulus pushes expected writes, reads and done-checksums; a monitor checks them.
module tb_mem_stream_loader;

    localparam int M      = 6;
    localparam int N      = 8;
    localparam int ADDR_W = $clog2(M);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [N-1:0]      data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              mode;
    logic [N-1:0]      in_data;
    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      out_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [N-1:0]      mem_wdata;
    logic              mem_we;
    logic [N-1:0]      mem_rdata;
    logic              busy;
    logic              done;
    logic [N-1:0]      checksum;

    logic [N-1:0]      mem [0:(1<<ADDR_W)-1];

    wr_t               exp_wr[$];
    logic [N-1:0]      exp_rd[$];
    logic [N-1:0]      exp_done[$];

    int n_checks = 0;
    int n_pass   = 0;

    mem_stream_loader #(.M(M), .N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    // Parent-side memory: synchronous write, combinational read.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                if (exp_wr.size() == 0) check("unexpected_write", 32'(mem_addr), 32'hFFFF);
                else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(e.addr));
                    check("wr_data", 32'(mem_wdata), 32'(e.data));
                end
            end
            if (out_valid) begin
                if (exp_rd.size() == 0) check("unexpected_read", 32'(out_data), 32'hFFFF);
                else begin
                    check("rd_data", 32'(out_data), 32'(exp_rd[0]));
                    if (out_ready) void'(exp_rd.pop_front());
                end
            end
            if (done) begin
                if (exp_done.size() == 0) check("unexpected_done", 32'(checksum), 32'hFFFF);
                else check("done_checksum", 32'(checksum), 32'(exp_done.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
        mode  = 1'b0;
    endtask

    task automatic write_words(input logic [N-1:0] first, input logic [N-1:0] step,
                               input int count, input bit gaps, input int base);
        for (int i = 0; i < count; i++) begin
            logic [N-1:0] w;
            int t;
            w = first + N'(i) * step;
            if (gaps) begin
                in_valid = 1'b0;
                tick();
                check("gap_addr_hold", 32'(mem_addr), 32'(base + i));
            end
            exp_wr.push_back('{addr: ADDR_W'(base + i), data: w});
            in_valid = 1'b1;
            in_data  = w;
            t = 0;
            while (!in_ready && t < 20) begin
                tick();
                t++;
            end
            if (t >= 20) check("in_ready_timeout", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Called one cycle after the final accept: DONE must be showing.
    task automatic finish_op(input logic [N-1:0] sum);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
        check("checksum", 32'(checksum), 32'(sum));
        tick();
        check("done_cleared", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        check("addr_home", 32'(mem_addr), 32'd0);
        check("checksum_hold", 32'(checksum), 32'(sum));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Back-to-back write load of 0x11..0x16
        exp_done.push_back(8'h75);
        do_start(1'b0);
        check("write_busy", 32'(busy), 32'd1);
        write_words(8'h11, 8'h01, M, 1'b0, 0);
        finish_op(8'h75);
        for (int i = 0; i < M; i++) check("mem_after_load", 32'(mem[i]), 32'(8'h11 + i));

        // Same load with gaps on in_valid
        exp_done.push_back(8'h75);
        do_start(1'b0);
        write_words(8'h11, 8'h01, M, 1'b1, 0);
        finish_op(8'h75);

        // Readback with alternating back-pressure
        for (int i = 0; i < M; i++) exp_rd.push_back(N'(8'h11 + i));
        exp_done.push_back(8'h75);
        do_start(1'b1);
        check("read_in_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < 40 && !done; k++) begin
            out_ready = (k % 2 == 0);
            tick();
        end
        out_ready = 1'b0;
        if (!done) check("read_timeout", 32'(done), 32'd1);
        finish_op(8'h75);
        check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);

        // Checksum wrap with 0xFF x6
        exp_done.push_back(8'hFA);
        do_start(1'b0);
        write_words(8'hFF, 8'h00, M, 1'b0, 0);
        finish_op(8'hFA);

        // start with mode=1 mid-write is ignored
        exp_done.push_back(8'hD5);
        do_start(1'b0);
        check("next_load_addr0", 32'(mem_addr), 32'd0);
        write_words(8'h21, 8'h01, 2, 1'b0, 0);
        start = 1'b1;
        mode  = 1'b1;
        tick();
        start = 1'b0;
        mode  = 1'b0;
        check("ignored_start_in_ready", 32'(in_ready), 32'd1);
        check("ignored_start_out_valid", 32'(out_valid), 32'd0);
        write_words(8'h23, 8'h01, 4, 1'b0, 2);
        finish_op(8'hD5);

        // Reset after three accepted writes
        do_start(1'b0);
        write_words(8'h31, 8'h01, 3, 1'b0, 0);
        check("pre_reset_checksum", 32'(checksum), 32'h96);
        in_valid = 1'b1;
        in_data  = 8'h34;
        #1;
        check("pre_reset_we", 32'(mem_we), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_we", 32'(mem_we), 32'd0);
        check("abort_checksum", 32'(checksum), 32'd0);
        check("abort_addr", 32'(mem_addr), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("kept_mem0", 32'(mem[0]), 32'h31);
        check("kept_mem1", 32'(mem[1]), 32'h32);
        check("kept_mem2", 32'(mem[2]), 32'h33);
        check("untouched_mem3", 32'(mem[3]), 32'h24);

        repeat (2) tick();
        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        check("done_queue_empty", 32'(exp_done.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
